// File: rtl/alu_pipe_seq_if.sv
// Handshake and operand/result bundle for alu_pipe_seq.
// The master side is the operand fetch / writeback stage; the slave side is the ALU.
interface alu_pipe_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic [3:0]       command;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, operandA, operandB, command, out_ready,
        input  in_ready, out_valid, result, carryout, zero, overflow, illegal
    );

    modport slave (
        input  in_valid, operandA, operandB, command, out_ready,
        output in_ready, out_valid, result, carryout, zero, overflow, illegal
    );
endinterface

// File: rtl/alu_pipe_seq.sv
// Registered ALU with valid/ready handshakes, shifts and a WIDTH-cycle shift-add multiply.
// Only one operation is in flight at a time; the output register holds under backpressure.
module alu_pipe_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MUL_EN = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_pipe_seq_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;
    localparam logic [SHW-1:0] LastCnt = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;

    state_e state_q, state_d;

    logic in_ready_c, out_valid_c;
    logic accept, is_mul, mul_done;

    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH:0]     mul_sum;
    logic [SHW-1:0]     cnt_q;

    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
    logic             out_we;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_ov, alu_ill;
    logic [WIDTH:0]   wide;
    logic [SHW-1:0]   shamt;

    assign is_mul   = (bus.command == 4'd8) && (MUL_EN != 0);
    assign accept   = bus.in_valid && in_ready_c;
    assign mul_done = (state_q == StMul) && (cnt_q == LastCnt);
    assign shamt    = bus.operandB[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_ov  = 1'b0;
        alu_ill = 1'b0;
        wide    = '0;
        case (bus.command)
            4'd0: begin
                wide    = {1'b0, bus.operandA} + {1'b0, bus.operandB};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_ov  = (bus.operandA[MSB] == bus.operandB[MSB]) &&
                          (alu_res[MSB] != bus.operandA[MSB]);
            end
            4'd1: begin
                wide    = {1'b0, bus.operandA} + {1'b0, ~bus.operandB} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_ov  = (bus.operandA[MSB] != bus.operandB[MSB]) &&
                          (alu_res[MSB] != bus.operandA[MSB]);
            end
            4'd2: alu_res = bus.operandA ^ bus.operandB;
            4'd3: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.operandA) < $signed(bus.operandB)};
            4'd4: alu_res = bus.operandA & bus.operandB;
            4'd5: alu_res = ~(bus.operandA & bus.operandB);
            4'd6: alu_res = ~(bus.operandA | bus.operandB);
            4'd7: alu_res = bus.operandA | bus.operandB;
            4'd8: alu_ill = (MUL_EN == 0);
            // Extra guard bit on the shifted side captures the last bit shifted out.
            4'd9: begin
                wide    = {1'b0, bus.operandA} << shamt;
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            4'd10: begin
                wide    = {bus.operandA, 1'b0} >> shamt;
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            4'd11: begin
                wide    = $signed({bus.operandA, 1'b0}) >>> shamt;
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // Upper half accumulates A when the current multiplier bit is set, then everything shifts right.
    always_comb begin
        mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
        p_d     = {mul_sum, p_q[WIDTH-1:1]};
    end

    always_comb begin
        out_we   = 1'b0;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        if (mul_done) begin
            out_we   = 1'b1;
            result_d = p_d[WIDTH-1:0];
            carry_d  = 1'b0;
            ovf_d    = |p_d[2*WIDTH-1:WIDTH];
            ill_d    = 1'b0;
        end else if (accept && !is_mul) begin
            out_we   = 1'b1;
            result_d = alu_res;
            carry_d  = alu_c;
            ovf_d    = alu_ov;
            ill_d    = alu_ill;
        end
        zero_d = out_we ? (result_d == '0) : zero_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = is_mul ? StMul : StHold;
            StMul:  if (mul_done) state_d = StHold;
            StHold: begin
                if (bus.out_ready) begin
                    if (accept) state_d = is_mul ? StMul : StHold;
                    else        state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            StIdle: in_ready_c = 1'b1;
            StMul:  in_ready_c = 1'b0;
            StHold: begin
                in_ready_c  = bus.out_ready;
                out_valid_c = 1'b1;
            end
            default: in_ready_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            if (accept && is_mul) begin
                a_q   <= bus.operandA;
                p_q   <= {{WIDTH{1'b0}}, bus.operandB};
                cnt_q <= '0;
            end else if (state_q == StMul) begin
                p_q   <= p_d;
                cnt_q <= cnt_q + SHW'(1);
            end
            if (out_we) begin
                result_q <= result_d;
                carry_q  <= carry_d;
                zero_q   <= zero_d;
                ovf_q    <= ovf_d;
                ill_q    <= ill_d;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.result    = result_q;
    assign bus.carryout  = carry_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_pipe_seq.sv
// Directed bench for alu_pipe_seq: hand-computed vectors covering each op class,
// multiply latency, backpressure, streaming and asynchronous reset mid-multiply.
module tb_alu_pipe_seq;
    localparam int unsigned W = 32;

    logic clk;
    logic reset_n;
    int   errs;
    int   checks;

    alu_pipe_seq_if #(.WIDTH(W)) bus ();

    alu_pipe_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = 1'b1;
        bus.command  = cmd;
        bus.operandA = a;
        bus.operandB = b;
        tick();
        bus.in_valid = 1'b0;
        bus.operandA = 'x;
        bus.operandB = 'x;
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] res, input logic c,
                             input logic z, input logic ov);
        check_eq({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        check_eq({tag, ".result"}, 64'(bus.result), 64'(res));
        check_eq({tag, ".flags"}, 64'({bus.carryout, bus.zero, bus.overflow}), 64'({c, z, ov}));
    endtask

    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output int busy_bad);
        lat      = 0;
        busy_bad = 0;
        do_op(4'd8, a, b);
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busy_bad++;
            tick();
            lat++;
        end
    endtask

    int lat, bad, stable_bad;

    initial begin
        errs   = 0;
        checks = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.command   = 4'd0;
        bus.operandA  = '0;
        bus.operandB  = '0;
        reset_n       = 1'b0;
        #12;
        check_eq("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst.result", 64'(bus.result), 64'd0);
        check_eq("rst.flags", 64'({bus.carryout, bus.zero, bus.overflow, bus.illegal}), 64'd0);
        reset_n = 1'b1;
        tick();
        check_eq("rst.in_ready", 64'(bus.in_ready), 64'd1);

        // T1
        do_op(4'd0, 32'd1, 32'd2);
        check_out("add1_2", 32'd3, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("add1_2.drain", 64'(bus.out_valid), 64'd0);

        // T2
        do_op(4'd1, 32'h8000_0000, 32'd1);
        check_out("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
        do_op(4'd3, 32'h8000_0000, 32'd1);
        check_out("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0);
        do_op(4'd3, 32'd5, 32'd5);
        check_out("slt_eq", 32'd0, 1'b0, 1'b1, 1'b0);
        tick();

        // T3
        run_mul(32'h0001_0000, 32'h0001_0000, lat, bad);
        check_eq("mul_big.latency", 64'(lat), 64'd32);
        check_eq("mul_big.in_ready_low", 64'(bad), 64'd0);
        check_out("mul_big", 32'd0, 1'b0, 1'b1, 1'b1);
        tick();
        run_mul(32'd6, 32'd7, lat, bad);
        check_eq("mul_6_7.latency", 64'(lat), 64'd32);
        check_eq("mul_6_7.in_ready_low", 64'(bad), 64'd0);
        check_out("mul_6_7", 32'd42, 1'b0, 1'b0, 1'b0);
        tick();

        // T4
        bus.out_ready = 1'b0;
        do_op(4'd0, 32'd7, 32'd8);
        bus.in_valid = 1'b1;
        bus.command  = 4'd2;
        bus.operandA = 32'h0000_F0F0;
        bus.operandB = 32'h0000_0FF0;
        stable_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.result !== 32'd15 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
                stable_bad++;
            tick();
        end
        check_eq("bp.stable", 64'(stable_bad), 64'd0);
        check_eq("bp.result", 64'(bus.result), 64'd15);
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp.in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check_out("bp.xor", 32'h0000_FF00, 1'b0, 1'b0, 1'b0);

        // T5
        for (int i = 0; i < 8; i++) begin
            check_eq("stream.in_ready", 64'(bus.in_ready), 64'd1);
            do_op(4'd0, 32'(3 * i), 32'(100 + i));
            check_eq("stream.valid", 64'(bus.out_valid), 64'd1);
            check_eq("stream.result", 64'(bus.result), 64'(100 + 4 * i));
        end
        tick();

        // T6
        do_op(4'd8, 32'd3, 32'd5);
        for (int i = 0; i < 10; i++) tick();
        check_eq("rstmul.busy", 64'(bus.in_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        check_eq("rstmul.out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rstmul.idle", 64'(bus.in_ready), 64'd1);
        #4;
        reset_n = 1'b1;
        tick();
        check_eq("rstmul.after", 64'(bus.out_valid), 64'd0);
        do_op(4'd0, 32'hFFFF_FFFF, 32'd1);
        check_out("add_wrap", 32'd0, 1'b1, 1'b1, 1'b0);
        do_op(4'd11, 32'h8000_0000, 32'd4);
        check_out("sra4", 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        do_op(4'd9, 32'h8000_0001, 32'd1);
        check_out("sll1", 32'd2, 1'b1, 1'b0, 1'b0);
        do_op(4'd10, 32'h0000_0003, 32'd1);
        check_out("srl1", 32'd1, 1'b1, 1'b0, 1'b0);
        do_op(4'd10, 32'h0000_0003, 32'd0);
        check_out("srl0", 32'd3, 1'b0, 1'b0, 1'b0);
        do_op(4'd15, 32'h1234_5678, 32'd9);
        check_out("illegal15", 32'd0, 1'b0, 1'b1, 1'b0);
        check_eq("illegal15.flag", 64'(bus.illegal), 64'd1);
        do_op(4'd4, 32'h0000_00FF, 32'h0000_000F);
        check_out("and", 32'h0000_000F, 1'b0, 1'b0, 1'b0);
        check_eq("and.illegal", 64'(bus.illegal), 64'd0);
        do_op(4'd6, 32'd0, 32'd0);
        check_out("nor", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        do_op(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_out("nand", 32'd0, 1'b0, 1'b1, 1'b0);
        do_op(4'd7, 32'hA000_0000, 32'h0000_0005);
        check_out("or", 32'hA000_0005, 1'b0, 1'b0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
